// File: rtl/pri_encoder8to3_hs.sv
// Sticky 8-bit request capture that serialises the pending requests as 3-bit codes over valid/ready.
// Registered outputs: a new request is offered one edge after capture, and one code is accepted per cycle; while ready=0 the offer is held.
module pri_encoder8to3_hs #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic [7:0] req,
  input  logic       ready,
  output logic [2:0] code,
  output logic [7:0] onehot,
  output logic       valid,
  output logic [7:0] pend,
  output logic       any_pend
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [7:0] onehot_q, onehot_d;
  logic [7:0] pend_q, pend_d;
  logic       valid_q, valid_d;
  logic [7:0] clr;
  logic [7:0] rem;

  // Later matches overwrite earlier ones, so the scan direction sets the priority.
  function automatic logic [2:0] sel(input logic [7:0] v);
    logic [2:0] s;
    s = 3'd0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) s = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) s = 3'(i);
      end
    end
    return s;
  endfunction

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    clr      = (valid_q && ready) ? onehot_q : 8'h00;
    rem      = pend_q & ~onehot_q;
    // Set wins over clear: a bit re-requested on its retire edge stays pending.
    pend_d   = (pend_q & ~clr) | (EN ? req : 8'h00);

    case (state_q)
      IDLE: begin
        if (pend_q != 8'h00) begin
          code_d   = sel(pend_q);
          onehot_d = 8'b1 << sel(pend_q);
          valid_d  = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          if (rem != 8'h00) begin
            code_d   = sel(rem);
            onehot_d = 8'b1 << sel(rem);
          end else begin
            valid_d  = 1'b0;
            onehot_d = 8'h00;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      code_q   <= 3'd0;
      onehot_q <= 8'h00;
      pend_q   <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      onehot_q <= onehot_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
    end
  end

  assign code     = code_q;
  assign onehot   = onehot_q;
  assign valid    = valid_q;
  assign pend     = pend_q;
  assign any_pend = |pend_q;

endmodule

// File: tb/tb_pri_encoder8to3_hs.sv
// Drives a high-first and a low-first encoder with shared stimulus and checks both against a request-set model.
module tb_pri_encoder8to3_hs;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       ready;

  logic [2:0] code_h, code_l;
  logic [7:0] onehot_h, onehot_l, pend_h, pend_l;
  logic       valid_h, valid_l, any_h, any_l;

  int vectors;
  int miscompares;

  // model state, index 0 = high-first, 1 = low-first
  int m_pend[2];
  int m_code[2];
  bit m_valid[2];

  pri_encoder8to3_hs #(.HIGH_FIRST(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .EN(en), .req(req), .ready(ready),
    .code(code_h), .onehot(onehot_h), .valid(valid_h), .pend(pend_h), .any_pend(any_h)
  );

  pri_encoder8to3_hs #(.HIGH_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .EN(en), .req(req), .ready(ready),
    .code(code_l), .onehot(onehot_l), .valid(valid_l), .pend(pend_l), .any_pend(any_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // highest set bit = floor(log2 v); lowest set bit = log2 of the isolated lowest bit
  function automatic int pick(input int v, input bit hf);
    if (hf) return $clog2(v + 1) - 1;
    return $clog2(v & -v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        m_pend[p]  <= 0;
        m_code[p]  <= 0;
        m_valid[p] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin : upd
        int old, clrm, r, nc;
        bit nv;
        old  = m_pend[p];
        clrm = 0;
        nc   = m_code[p];
        nv   = m_valid[p];
        if (m_valid[p]) begin
          if (ready) begin
            clrm = 1 << m_code[p];
            r    = old & ~clrm;
            if (r != 0) nc = pick(r, p == 0);
            else        nv = 1'b0;
          end
        end else if (old != 0) begin
          nc = pick(old, p == 0);
          nv = 1'b1;
        end
        m_pend[p]  <= (old & ~clrm) | (en ? int'(req) : 0);
        m_code[p]  <= nc;
        m_valid[p] <= nv;
      end
    end
  end

  always @(negedge clk) begin
    chk("h_pend",   int'(pend_h),   m_pend[0]);
    chk("h_any",    int'(any_h),    int'(m_pend[0] != 0));
    chk("h_valid",  int'(valid_h),  int'(m_valid[0]));
    chk("h_code",   int'(code_h),   m_code[0]);
    chk("h_onehot", int'(onehot_h), m_valid[0] ? (1 << m_code[0]) : 0);
    chk("l_pend",   int'(pend_l),   m_pend[1]);
    chk("l_any",    int'(any_l),    int'(m_pend[1] != 0));
    chk("l_valid",  int'(valid_l),  int'(m_valid[1]));
    chk("l_code",   int'(code_l),   m_code[1]);
    chk("l_onehot", int'(onehot_l), m_valid[1] ? (1 << m_code[1]) : 0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    ready = 1'b0;
    #13;
    chk("rst_valid", int'(valid_h), 0);
    chk("rst_pend",  int'(pend_h),  0);
    chk("rst_oh",    int'(onehot_h), 0);
    tick();
    rst_n = 1'b1;

    // basic order
    en = 1'b1; ready = 1'b1; req = 8'h24;
    tick(); req = 8'h00;
    chk("b1_pend", int'(pend_h), 'h24);
    chk("b1_valid", int'(valid_h), 0);
    tick();
    chk("b2_valid", int'(valid_h), 1);
    chk("b2_code", int'(code_h), 5);
    chk("b2_oh", int'(onehot_h), 'h20);
    chk("b2_lcode", int'(code_l), 2);
    tick();
    chk("b3_code", int'(code_h), 2);
    chk("b3_pend", int'(pend_h), 'h04);
    tick();
    chk("b4_valid", int'(valid_h), 0);
    chk("b4_pend", int'(pend_h), 0);

    // backpressure
    ready = 1'b0; req = 8'h04;
    tick(); req = 8'h00;
    tick();
    chk("bp_code0", int'(code_h), 2);
    req = 8'h80;
    tick(); req = 8'h00;
    tick();
    chk("bp_hold", int'(code_h), 2);
    chk("bp_pend", int'(pend_h), 'h84);
    ready = 1'b1;
    tick();
    chk("bp_next", int'(code_h), 7);
    chk("bp_pend2", int'(pend_h), 'h80);
    tick();
    chk("bp_done", int'(valid_h), 0);
    ready = 1'b0;

    // set-over-clear
    req = 8'h08;
    tick(); req = 8'h00;
    tick();
    chk("soc_code", int'(code_h), 3);
    ready = 1'b1; req = 8'h08;
    tick(); req = 8'h00;
    chk("soc_pend", int'(pend_h), 'h08);
    tick();
    chk("soc_valid", int'(valid_h), 1);
    chk("soc_code2", int'(code_h), 3);
    tick();
    chk("soc_pend0", int'(pend_h), 0);

    // EN gating then drain
    ready = 1'b1; en = 1'b0; req = 8'hFF;
    repeat (5) tick();
    chk("en_pend", int'(pend_h), 0);
    chk("en_valid", int'(valid_h), 0);
    en = 1'b1;
    tick(); en = 1'b0; req = 8'h00;
    chk("en_cap", int'(pend_h), 'hFF);
    for (int k = 7; k >= 0; k--) begin
      tick();
      chk("drain_code", int'(code_h), k);
      chk("drain_valid", int'(valid_h), 1);
    end
    tick();
    chk("drain_end", int'(valid_h), 0);
    en = 1'b1;

    // low-first order
    req = 8'h81;
    tick(); req = 8'h00;
    tick();
    chk("lf_c0", int'(code_l), 0);
    tick();
    chk("lf_c7", int'(code_l), 7);
    tick();
    chk("lf_end", int'(valid_l), 0);

    // asynchronous reset mid-stream
    ready = 1'b0; req = 8'hFF;
    tick(); req = 8'h00;
    tick();
    chk("ar_pre_valid", int'(valid_h), 1);
    chk("ar_pre_pend", int'(pend_h), 'hFF);
    rst_n = 1'b0;
    #1;
    chk("ar_pend", int'(pend_h), 0);
    chk("ar_valid", int'(valid_h), 0);
    chk("ar_code", int'(code_h), 0);
    chk("ar_oh", int'(onehot_h), 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("ar_idle", int'(valid_h), 0);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      en    = ($urandom_range(0, 3) != 0);
      ready = ($urandom_range(0, 2) != 0);
      req   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
